// File: rtl/chan_burst_framer_pkg.sv
// Shared types and widths for the channel burst framer.
package chan_burst_framer_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam int SEQ_WIDTH     = 12;
    localparam int PKT_CNT_WIDTH = 16;

endpackage

// File: rtl/axi_skid_2.sv
// Two-entry AXI-Stream skid buffer; the upstream ready is a pure register of the fill level.
module axi_skid_2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         sync_reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic [1:0]   count;
    logic [1:0]   count_nxt;
    logic         wr_ptr;
    logic         rd_ptr;
    logic         ready_q;
    logic         push;
    logic         pop;

    assign push      = in_valid & ready_q;
    assign pop       = out_valid & out_ready;
    assign count_nxt = count + 2'(push) - 2'(pop);
    assign in_ready  = ready_q;
    assign out_valid = (count != 2'd0);
    // Payload is forced to zero when empty so reset leaves every output field clear.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            count   <= count_nxt;
            ready_q <= (count_nxt != 2'd2);
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/chan_burst_framer.sv
// Re-frames the downselected sample stream into packets bounded by length, frame end and burst end.
module chan_burst_framer
    import chan_burst_framer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int TUSER_WIDTH = 24,
    parameter int LEN_WIDTH   = 12
) (
    input  logic                     clk,
    input  logic                     sync_reset,
    input  logic                     s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_eob,
    output logic                     s_axis_tready,
    input  logic [LEN_WIDTH-1:0]     cfg_max_len,
    output logic                     m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic                     m_axis_eob,
    output logic [SEQ_WIDTH-1:0]     m_axis_seq,
    input  logic                     m_axis_tready,
    output logic [PKT_CNT_WIDTH-1:0] pkt_count
);

    localparam int PAYLOAD_W = SEQ_WIDTH + 2 + TUSER_WIDTH + DATA_WIDTH;

    state_t                   state;
    logic [LEN_WIDTH-1:0]     cnt;
    logic [LEN_WIDTH-1:0]     len_q;
    logic [SEQ_WIDTH-1:0]     seq_q;
    logic                     accept_p0;
    logic                     close_p0;
    logic [LEN_WIDTH-1:0]     len_p0;
    logic [LEN_WIDTH-1:0]     cnt_p0;
    logic [PAYLOAD_W-1:0]     payload_p0;
    logic [PAYLOAD_W-1:0]     payload_p1;
    logic                     vld_p1;

    assign accept_p0 = s_axis_tvalid & s_axis_tready;

    // Framing decision for the beat being accepted this cycle
    always_comb begin
        len_p0 = len_q;
        cnt_p0 = cnt + LEN_WIDTH'(1);
        if (state == IDLE) begin
            len_p0 = (cfg_max_len == '0) ? LEN_WIDTH'(1) : cfg_max_len;
            cnt_p0 = LEN_WIDTH'(1);
        end
        close_p0 = (cnt_p0 == len_p0) | s_axis_tlast | s_axis_eob;
    end

    assign payload_p0 = {seq_q, s_axis_eob, close_p0, s_axis_tuser, s_axis_tdata};

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            state <= IDLE;
            cnt   <= '0;
            len_q <= '0;
            seq_q <= '0;
        end else if (accept_p0) begin
            if (close_p0) begin
                state <= IDLE;
                cnt   <= '0;
                // A burst end restarts numbering so every burst begins at seq 0.
                seq_q <= s_axis_eob ? '0 : seq_q + SEQ_WIDTH'(1);
            end else begin
                state <= ACTIVE;
                cnt   <= cnt_p0;
                len_q <= len_p0;
            end
        end
    end

    // Stage 1: skid buffer decouples output backpressure from input ready
    axi_skid_2 #(
        .W(PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .sync_reset(sync_reset),
        .in_valid  (s_axis_tvalid),
        .in_ready  (s_axis_tready),
        .in_data   (payload_p0),
        .out_valid (vld_p1),
        .out_ready (m_axis_tready),
        .out_data  (payload_p1)
    );

    assign m_axis_tvalid = vld_p1;
    assign {m_axis_seq, m_axis_eob, m_axis_tlast, m_axis_tuser, m_axis_tdata} = payload_p1;

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            pkt_count <= '0;
        end else if (vld_p1 & m_axis_tready & m_axis_tlast) begin
            pkt_count <= pkt_count + PKT_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_chan_burst_framer.sv
// Self-checking bench for chan_burst_framer: directed vector tables plus a randomized backpressure run.
module tb_chan_burst_framer;

    logic        clk = 1'b0;
    logic        sync_reset = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic [23:0] s_axis_tuser = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_eob = 1'b0;
    logic        s_axis_tready;
    logic [11:0] cfg_max_len = 12'd4;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic [23:0] m_axis_tuser;
    logic        m_axis_tlast;
    logic        m_axis_eob;
    logic [11:0] m_axis_seq;
    logic        m_axis_tready = 1'b0;
    logic [15:0] pkt_count;

    chan_burst_framer #(
        .DATA_WIDTH(32),
        .TUSER_WIDTH(24),
        .LEN_WIDTH(12)
    ) dut (
        .clk          (clk),
        .sync_reset   (sync_reset),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_eob   (s_axis_eob),
        .s_axis_tready(s_axis_tready),
        .cfg_max_len  (cfg_max_len),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_eob   (m_axis_eob),
        .m_axis_seq   (m_axis_seq),
        .m_axis_tready(m_axis_tready),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] seq;
        logic        eob;
        logic        last;
        logic [23:0] user;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        eob;
        logic [11:0] cfg;
        logic        xl;
        logic        xe;
        logic [11:0] xs;
    } vec_t;

    beat_t exp_q[$];
    vec_t  vecs[$];
    int    checks = 0;
    int    errors = 0;

    bit    mon_on = 1'b0;
    bit    rand_rdy = 1'b0;
    bit    hold_rdy = 1'b0;
    bit    occ_on = 1'b0;
    bit    stalled = 1'b0;
    int    occ = 0;
    int    occ_err = 0;
    beat_t got;
    beat_t held;

    bit          m_open;
    int          m_cnt;
    int          m_len;
    logic [11:0] m_seq;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_rdy)      m_axis_tready = 1'b0;
            else if (rand_rdy) m_axis_tready = ($urandom_range(0, 1) == 1);
            else               m_axis_tready = 1'b1;
        end
    end

    // Output monitor: scoreboard pop, hold-while-stalled and occupancy/ready tracking
    always @(negedge clk) begin
        if (!mon_on || sync_reset) begin
            stalled = 1'b0;
            occ = 0;
        end else begin
            got = {m_axis_seq, m_axis_eob, m_axis_tlast, m_axis_tuser, m_axis_tdata};
            if (stalled)
                check("stall_hold", 80'({m_axis_tvalid, got}), 80'({1'b1, held}));
            if (occ_on && ((s_axis_tready !== (occ < 2)) || (m_axis_tvalid !== (occ != 0))))
                occ_err++;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected none", got);
                end else begin
                    check("beat", 80'(got), 80'(exp_q.pop_front()));
                end
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            held = got;
            occ = occ + int'(s_axis_tvalid && s_axis_tready) - int'(m_axis_tvalid && m_axis_tready);
        end
    end

    task automatic send(input logic [31:0] d, input logic l, input logic e, input logic [11:0] cfg,
                        input logic xl, input logic xe, input logic [11:0] xs);
        beat_t b;
        int n;
        s_axis_tdata  = d;
        s_axis_tuser  = d[23:0] ^ 24'hA5C300;
        s_axis_tlast  = l;
        s_axis_eob    = e;
        cfg_max_len   = cfg;
        s_axis_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axis_tready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!s_axis_tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_axis_tready got 0 expected 1");
        end
        b.seq  = xs;
        b.eob  = xe;
        b.last = xl;
        b.user = s_axis_tuser;
        b.data = d;
        exp_q.push_back(b);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic add(input logic [31:0] d, input logic l, input logic e, input logic [11:0] cfg,
                       input logic xl, input logic xe, input logic [11:0] xs);
        vecs.push_back('{d, l, e, cfg, xl, xe, xs});
    endtask

    task automatic run_vecs();
        foreach (vecs[i])
            send(vecs[i].data, vecs[i].last, vecs[i].eob, vecs[i].cfg, vecs[i].xl, vecs[i].xe, vecs[i].xs);
        vecs.delete();
    endtask

    task automatic model_send(input logic [31:0] d, input logic l, input logic e, input logic [11:0] cfg);
        logic xl;
        logic [11:0] xs;
        if (!m_open) begin
            m_len = (cfg == 12'd0) ? 1 : int'(cfg);
            m_cnt = 0;
        end
        m_cnt++;
        xl = (m_cnt == m_len) || l || e;
        xs = m_seq;
        if (xl) begin
            m_open = 1'b0;
            m_seq  = e ? 12'd0 : m_seq + 12'd1;
        end else begin
            m_open = 1'b1;
        end
        send(d, l, e, cfg, xl, e, xs);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        sync_reset = 1'b1;
        #1;
        check("rst_m_tvalid", 80'(m_axis_tvalid), 80'(0));
        check("rst_m_tlast", 80'(m_axis_tlast), 80'(0));
        check("rst_m_eob", 80'(m_axis_eob), 80'(0));
        check("rst_m_seq", 80'(m_axis_seq), 80'(0));
        check("rst_pkt_count", 80'(pkt_count), 80'(0));
        check("rst_s_tready", 80'(s_axis_tready), 80'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        sync_reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_tready", 80'(s_axis_tready), 80'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        mon_on = 1'b1;

        // Length split: closes on beats 4 and 8, last two beats left open
        for (int i = 0; i < 10; i++)
            add(32'h100 + 32'(i), 1'b0, 1'b0, 12'd4, (i == 3 || i == 7), 1'b0, 12'(i / 4));
        run_vecs();
        drain();
        check("len_split_pkt_count", 80'(pkt_count), 80'(2));

        // Frame split: tlast on beat 5, then a full 8-beat packet
        do_reset();
        for (int i = 0; i < 5; i++)
            add(32'h200 + 32'(i), (i == 4), 1'b0, 12'd8, (i == 4), 1'b0, 12'd0);
        for (int i = 0; i < 8; i++)
            add(32'h210 + 32'(i), 1'b0, 1'b0, 12'd8, (i == 7), 1'b0, 12'd1);
        run_vecs();
        drain();
        check("frame_split_pkt_count", 80'(pkt_count), 80'(2));

        // Burst end, then simultaneous tlast+eob on a length hit
        do_reset();
        add(32'h300, 1'b0, 1'b0, 12'd3, 1'b0, 1'b0, 12'd0);
        add(32'h301, 1'b0, 1'b0, 12'd3, 1'b0, 1'b0, 12'd0);
        add(32'h302, 1'b0, 1'b1, 12'd3, 1'b1, 1'b1, 12'd0);
        add(32'h303, 1'b0, 1'b0, 12'd3, 1'b0, 1'b0, 12'd0);
        add(32'h304, 1'b1, 1'b0, 12'd3, 1'b1, 1'b0, 12'd0);
        add(32'h305, 1'b1, 1'b1, 12'd1, 1'b1, 1'b1, 12'd1);
        add(32'h306, 1'b1, 1'b0, 12'd3, 1'b1, 1'b0, 12'd0);
        run_vecs();
        drain();
        check("burst_pkt_count", 80'(pkt_count), 80'(4));

        // cfg_max_len 0 acts as 1; a mid-packet length change waits for the next packet
        do_reset();
        for (int i = 0; i < 3; i++)
            add(32'h400 + 32'(i), 1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 12'(i));
        for (int i = 0; i < 5; i++)
            add(32'h410 + 32'(i), 1'b0, 1'b0, (i < 2) ? 12'd5 : 12'd2, (i == 4), 1'b0, 12'd3);
        for (int i = 0; i < 2; i++)
            add(32'h420 + 32'(i), 1'b0, 1'b0, 12'd2, (i == 1), 1'b0, 12'd4);
        run_vecs();
        drain();
        check("cfg_edge_pkt_count", 80'(pkt_count), 80'(5));

        // Reset mid-packet with both skid entries held
        hold_rdy = 1'b1;
        @(posedge clk);
        #1;
        send(32'h500, 1'b0, 1'b0, 12'd6, 1'b0, 1'b0, 12'd5);
        send(32'h501, 1'b0, 1'b0, 12'd6, 1'b0, 1'b0, 12'd5);
        @(negedge clk);
        check("pre_reset_m_tvalid", 80'(m_axis_tvalid), 80'(1));
        check("pre_reset_s_tready", 80'(s_axis_tready), 80'(0));
        do_reset();
        hold_rdy = 1'b0;
        add(32'h510, 1'b0, 1'b0, 12'd2, 1'b0, 1'b0, 12'd0);
        add(32'h511, 1'b0, 1'b0, 12'd2, 1'b1, 1'b0, 12'd0);
        add(32'h512, 1'b0, 1'b0, 12'd2, 1'b0, 1'b0, 12'd1);
        run_vecs();
        drain();
        check("post_reset_pkt_count", 80'(pkt_count), 80'(1));

        // Randomized backpressure run against the reference model
        do_reset();
        m_open = 1'b0;
        m_seq = 12'd0;
        m_cnt = 0;
        m_len = 1;
        occ_err = 0;
        rand_rdy = 1'b1;
        @(posedge clk);
        #1;
        occ_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
            model_send($urandom(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), 12'd7);
        end
        rand_rdy = 1'b0;
        drain();
        occ_on = 1'b0;
        check("ready_occupancy_errors", 80'(occ_err), 80'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
